// File: rtl/ex_muldiv_if.sv
// Issue/writeback bundle between id_ex/ctrl and the iterative M unit.
// Master drives the op, slave returns the register write and stall.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      func3_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic [4:0]      rd_addr_o;
  logic [XLEN-1:0] rd_data_o;
  logic            rd_wen_o;
  logic            hold_flag_o;
  logic            busy_o;

  modport master (
    output start_i, func3_i, op1_i, op2_i,
    output rd_addr_i, flush_i,
    input  rd_addr_o, rd_data_o, rd_wen_o,
    input  hold_flag_o, busy_o
  );

  modport slave (
    input  start_i, func3_i, op1_i, op2_i,
    input  rd_addr_i, flush_i,
    output rd_addr_o, rd_data_o, rd_wen_o,
    output hold_flag_o, busy_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply,
// restoring divide, sign fix-up, one register write per op.
module ex_muldiv #(
  parameter int XLEN             = 32,
  parameter int MUL_BITS_PER_CYC = 1
) (
  input logic         clk,
  input logic         rst,
  ex_muldiv_if.slave  bus
);
  localparam int K       = MUL_BITS_PER_CYC;
  localparam int CW      = $clog2(XLEN) + 1;
  localparam int MUL_LIM = XLEN / K;
  localparam int DIV_LIM = XLEN;
  localparam logic [XLEN-1:0] MIN =
    {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DIV, S_DONE
  } state_t;

  state_t            state;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic              neg_q;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic              wen_q;
  logic [4:0]        rd_addr_q;
  logic [XLEN-1:0]   rd_data_q;

  logic              sg1, sg2, s1, s2, neg_in;
  logic              dz, ovf;
  logic [XLEN-1:0]   mag1, mag2, fast;
  logic [2*XLEN-1:0] acc_add, mul_full;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN:0]     r_sh, diff;
  logic [XLEN-1:0]   rem_n, quo_n, div_raw, div_res;

  // Operand decode at accept: signedness, magnitudes, fast path.
  always_comb begin
    sg1 = !(bus.func3_i inside {3'b011, 3'b101, 3'b111});
    sg2 = bus.func3_i inside {3'b000, 3'b001, 3'b100, 3'b110};
    s1  = sg1 & bus.op1_i[XLEN-1];
    s2  = sg2 & bus.op2_i[XLEN-1];
    mag1 = s1 ? -bus.op1_i : bus.op1_i;
    mag2 = s2 ? -bus.op2_i : bus.op2_i;
    neg_in = (bus.func3_i[2] & bus.func3_i[1]) ? s1 : (s1 ^ s2);
    dz  = bus.func3_i[2] & (bus.op2_i == '0);
    ovf = bus.func3_i[2] & ~bus.func3_i[0] &
          (bus.op1_i == MIN) & (bus.op2_i == '1);
    fast = '0;
    if (dz) fast = bus.func3_i[1] ? bus.op1_i : '1;
    else    fast = bus.func3_i[1] ? '0 : MIN;
  end

  // One multiply step and one restoring-divide step per cycle.
  always_comb begin
    acc_add  = acc + mcand *
               {{(2*XLEN-K){1'b0}}, mplier[K-1:0]};
    mul_full = neg_q ? -acc_add : acc_add;
    mul_res  = (f3_q[1:0] == 2'b00) ?
               mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
    r_sh  = {acc[XLEN-1:0], mplier[XLEN-1]};
    diff  = r_sh - {1'b0, mcand[XLEN-1:0]};
    rem_n = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
    quo_n = {mplier[XLEN-2:0], ~diff[XLEN]};
    div_raw = f3_q[1] ? rem_n : quo_n;
    div_res = neg_q ? -div_raw : div_raw;
  end

  // Control FSM, iteration datapath and registered writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      f3_q      <= '0;
      rd_q      <= '0;
      neg_q     <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      wen_q     <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      wen_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start_i && !bus.flush_i) begin
            f3_q  <= bus.func3_i;
            rd_q  <= bus.rd_addr_i;
            neg_q <= neg_in;
            cnt   <= '0;
            acc   <= '0;
            if (dz || ovf) begin
              state     <= S_DONE;
              rd_addr_q <= bus.rd_addr_i;
              rd_data_q <= fast;
              wen_q     <= bus.rd_addr_i != 5'd0;
            end else if (bus.func3_i[2]) begin
              state  <= S_DIV;
              mcand  <= {{XLEN{1'b0}}, mag2};
              mplier <= mag1;
            end else begin
              state  <= S_MUL;
              mcand  <= {{XLEN{1'b0}}, mag1};
              mplier <= mag2;
            end
          end
        end
        S_MUL: begin
          if (bus.flush_i) begin
            state <= S_IDLE;
          end else begin
            acc    <= acc_add;
            mcand  <= mcand << K;
            mplier <= mplier >> K;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(MUL_LIM - 1)) begin
              state     <= S_DONE;
              rd_addr_q <= rd_q;
              rd_data_q <= mul_res;
              wen_q     <= rd_q != 5'd0;
            end
          end
        end
        S_DIV: begin
          if (bus.flush_i) begin
            state <= S_IDLE;
          end else begin
            acc    <= {{XLEN{1'b0}}, rem_n};
            mplier <= quo_n;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(DIV_LIM - 1)) begin
              state     <= S_DONE;
              rd_addr_q <= rd_q;
              rd_data_q <= div_res;
              wen_q     <= rd_q != 5'd0;
            end
          end
        end
        S_DONE: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_addr_o   = rd_addr_q;
  assign bus.rd_data_o   = rd_data_q;
  assign bus.rd_wen_o    = wen_q & ~bus.flush_i;
  assign bus.busy_o      = state != S_IDLE;
  assign bus.hold_flag_o =
    (bus.start_i & ~bus.flush_i & (state == S_IDLE)) |
    (state == S_MUL) | (state == S_DIV);
endmodule
